seq_detector_ctrl: RTL

SEQ_DETECTOR_CTRL -- requirements
Module: seq_detector_ctrl

---
 rtl/seq_detector_pkg.sv | 30 +++
 rtl/seq_rr_arb.sv | 46 ++++
 rtl/seq_detector_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seq_detector_pkg.sv
// rtl/seq_detector_pkg.sv - shared types, widths and helpers for the sequence detector controller
package seq_detector_pkg;

    // Burst geometry: NIBBLES data beats of DATA_W bits each, carried in one SEQ word.
    localparam int NIBBLES = 4;
    localparam int MODE_W  = 2;
    localparam int DATA_W  = 4;
    localparam int SEQ_W   = NIBBLES * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STREAM = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    // Nibble 0 sits in the least significant bits and goes out first.
    function automatic logic [DATA_W-1:0] nibble_sel(input logic [SEQ_W-1:0] seq,
                                                     input logic [1:0]       idx);
        logic [DATA_W-1:0] nib;
        case (idx)
            2'd0:    nib = seq[3:0];
            2'd1:    nib = seq[7:4];
            2'd2:    nib = seq[11:8];
            default: nib = seq[15:12];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/seq_rr_arb.sv
// rtl/seq_rr_arb.sv - two-way round-robin arbiter with a last-served pointer
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   req[1:0]  - request vector
//   advance   - arbitration is live this cycle; pointer moves when a grant is taken
//   grant[1:0]- one-hot grant (all zero when no request), combinational
module seq_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // last_q = index of the requester served most recently. Resetting it to 1
    // makes requester 0 the winner of the first contention.
    logic last_q;
    logic last_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance && (req != 2'b00)) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/seq_detector_ctrl.sv
// rtl/seq_detector_ctrl.sv - arbitrates two requesters and streams their 4-nibble bursts to a detector
//
// Ports:
//   SYSCLK, RST         - clock and synchronous active-high reset
//   REQ0/REQ1           - requests, held until the matching GNT
//   MODE0/MODE1         - detector mode per requester, latched at grant
//   SEQ0/SEQ1           - four nibbles per requester, [3:0] first, latched at grant
//   GNT0/GNT1           - one-cycle pulse, coincident with SETUP
//   DONE0/DONE1         - one-cycle pulse on the cycle after the last STREAM beat
//   BUSY                - high in every state but IDLE
//   IN_VALID/MODE/DATA_IN - registered detector drive
module seq_detector_ctrl
    import seq_detector_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic              SYSCLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic [MODE_W-1:0] MODE0,
    input  logic [MODE_W-1:0] MODE1,
    input  logic [SEQ_W-1:0]  SEQ0,
    input  logic [SEQ_W-1:0]  SEQ1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              DONE0,
    output logic              DONE1,
    output logic              BUSY,
    output logic              IN_VALID,
    output logic [MODE_W-1:0] MODE,
    output logic [DATA_W-1:0] DATA_IN
);

    localparam logic [1:0] LAST_NIB = 2'(NIBBLES - 1);
    // GAP is entered with the counter preloaded to GAP_CYCLES-1 and left when it reads 0.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_e             state_q,    state_d;
    logic [1:0]         nib_cnt_q,  nib_cnt_d;
    logic [3:0]         gap_cnt_q,  gap_cnt_d;
    logic [SEQ_W-1:0]   seq_q,      seq_d;
    logic [MODE_W-1:0]  mode_q,     mode_d;
    logic               owner_q,    owner_d;
    logic [1:0]         gnt_q,      gnt_d;
    logic [1:0]         done_q,     done_d;
    logic               in_valid_q, in_valid_d;
    logic [DATA_W-1:0]  data_in_q,  data_in_d;

    logic [1:0]         arb_grant;

    // Requests only matter while IDLE, so the arbiter pointer advances only there.
    seq_rr_arb u_arb (
        .clk     (SYSCLK),
        .rst     (RST),
        .req     ({REQ1, REQ0}),
        .advance (state_q == ST_IDLE),
        .grant   (arb_grant)
    );

    // Every output register is loaded from the next state so that the outputs
    // line up with the state they describe (e.g. GNT during SETUP).
    always_comb begin
        state_d    = state_q;
        nib_cnt_d  = nib_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        seq_d      = seq_q;
        mode_d     = mode_q;
        owner_d    = owner_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        in_valid_d = 1'b0;
        data_in_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_grant != 2'b00) begin
                    state_d = ST_SETUP;
                    gnt_d   = arb_grant;
                    owner_d = arb_grant[1];
                    seq_d   = arb_grant[1] ? SEQ1  : SEQ0;
                    mode_d  = arb_grant[1] ? MODE1 : MODE0;
                end
            end

            ST_SETUP: begin
                state_d    = ST_STREAM;
                nib_cnt_d  = 2'd0;
                in_valid_d = 1'b1;
                data_in_d  = nibble_sel(seq_q, 2'd0);
            end

            ST_STREAM: begin
                if (nib_cnt_q == LAST_NIB) begin
                    nib_cnt_d = 2'd0;
                    done_d    = owner_q ? 2'b10 : 2'b01;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end else begin
                    nib_cnt_d  = nib_cnt_q + 2'd1;
                    in_valid_d = 1'b1;
                    data_in_d  = nibble_sel(seq_q, nib_cnt_q + 2'd1);
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            nib_cnt_q  <= 2'd0;
            gap_cnt_q  <= 4'd0;
            seq_q      <= '0;
            mode_q     <= '0;
            owner_q    <= 1'b0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            in_valid_q <= 1'b0;
            data_in_q  <= '0;
        end else begin
            state_q    <= state_d;
            nib_cnt_q  <= nib_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            seq_q      <= seq_d;
            mode_q     <= mode_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            in_valid_q <= in_valid_d;
            data_in_q  <= data_in_d;
        end
    end

    assign GNT0     = gnt_q[0];
    assign GNT1     = gnt_q[1];
    assign DONE0    = done_q[0];
    assign DONE1    = done_q[1];
    assign BUSY     = (state_q != ST_IDLE);
    assign IN_VALID = in_valid_q;
    assign MODE     = mode_q;
    assign DATA_IN  = data_in_q;

endmodule
